// File: rtl/scalar_pipelined_multiplication_unit.sv
// Scalar pipelined integer multiplier: MUL/MULH/MULHSU/MULHU at XLEN plus MULW.
// Operands are decoded into magnitudes plus a negate flag in the first stage.
// The magnitude product is formed in the next stage. The final stage applies
// the sign correction and the result selection. A valid/ready handshake with
// whole-pipeline stall is provided, together with a flush that squashes all
// in-flight operations.
module scalar_pipelined_multiplication_unit #(
  parameter int XLEN   = 64,
  parameter int STAGES = 3,
  parameter int TAG_W  = 5
) (
  input  logic                clock_i,
  input  logic                reset_ni,
  input  logic                flush_i,
  input  logic                request_i,
  output logic                ready_o,
  input  logic [2:0]          funct3_i,
  input  logic                word_i,
  input  logic [XLEN-1:0]     rs1_i,
  input  logic [XLEN-1:0]     rs2_i,
  input  logic [TAG_W-1:0]    tag_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [XLEN-1:0]     rd_o,
  output logic [2*XLEN-1:0]   rd_complete_o,
  output logic [TAG_W-1:0]    tag_o,
  output logic                busy_o
);

  // Control that travels alongside the data through every stage.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             neg;   // operand signs differ: negate magnitude product
    logic             zero;  // funct3 1xx: result forced to zero
    logic             high;  // return upper half of the product
    logic             word;  // MULW: sign-extend low 32 bits of product
  } ctl_t;

  logic                word_eff;
  logic                a_signed;
  logic                b_signed;
  logic                a_neg;
  logic                b_neg;
  logic [XLEN-1:0]     op_a;
  logic [XLEN-1:0]     op_b;
  logic [XLEN-1:0]     a_mag;
  logic [XLEN-1:0]     b_mag;
  ctl_t                ctl_in;

  logic                stall;
  logic                advance;
  logic                accept;

  // Stage 0 holds {b_mag, a_mag}; stages 1..STAGES-2 hold the magnitude product.
  logic [STAGES-1:0]   valid_reg;
  logic [2*XLEN-1:0]   prod_reg [STAGES-1];
  ctl_t                ctl_reg  [STAGES-1];

  logic [2*XLEN-1:0]   mag_prod;
  logic [2*XLEN-1:0]   last_mag;
  ctl_t                last_ctl;
  logic [2*XLEN-1:0]   signed_next;
  logic [XLEN-1:0]     rd_next;
  logic [2*XLEN-1:0]   full_next;

  logic [XLEN-1:0]     rd_reg;
  logic [2*XLEN-1:0]   full_reg;
  logic [TAG_W-1:0]    tag_reg;

  // Handshake: the whole pipeline freezes while the output is held.
  assign stall   = valid_reg[STAGES-1] && !ready_i;
  assign advance = !stall;
  assign accept  = request_i && advance && !flush_i;
  assign ready_o = advance;

  // Decode signedness and reduce each operand to a magnitude plus a sign flag.
  always_comb begin
    word_eff     = (XLEN == 64) && word_i;
    a_signed     = word_eff || (funct3_i[1:0] != 2'b11);
    b_signed     = word_eff || !funct3_i[1];
    op_a         = word_eff ? XLEN'($signed(rs1_i[31:0])) : rs1_i;
    op_b         = word_eff ? XLEN'($signed(rs2_i[31:0])) : rs2_i;
    a_neg        = a_signed && op_a[XLEN-1];
    b_neg        = b_signed && op_b[XLEN-1];
    a_mag        = a_neg ? -op_a : op_a;
    b_mag        = b_neg ? -op_b : op_b;
    ctl_in.tag   = tag_i;
    ctl_in.neg   = a_neg ^ b_neg;
    ctl_in.zero  = !word_eff && funct3_i[2];
    ctl_in.high  = !word_eff && (funct3_i[1:0] != 2'b00);
    ctl_in.word  = word_eff;
  end

  // Unsigned magnitude multiply of the registered operands.
  assign mag_prod = {{XLEN{1'b0}}, prod_reg[0][XLEN-1:0]} *
                    {{XLEN{1'b0}}, prod_reg[0][2*XLEN-1:XLEN]};

  // With two stages the product feeds the output register directly.
  assign last_mag = (STAGES == 2) ? mag_prod : prod_reg[STAGES-2];
  assign last_ctl = ctl_reg[STAGES-2];

  // Sign correction and result selection ahead of the output register.
  always_comb begin
    signed_next = last_ctl.neg ? -last_mag : last_mag;
    rd_next     = '0;
    full_next   = '0;
    if (!last_ctl.zero) begin
      full_next = signed_next;
      if (last_ctl.word) begin
        rd_next = XLEN'($signed(signed_next[31:0]));
      end else if (last_ctl.high) begin
        rd_next = signed_next[2*XLEN-1:XLEN];
      end else begin
        rd_next = signed_next[XLEN-1:0];
      end
    end
  end

  // Operand and middle stages: flush drops validity, stall freezes everything.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      valid_reg <= '0;
      for (int i = 0; i < STAGES-1; i++) begin
        prod_reg[i] <= '0;
        ctl_reg[i]  <= '0;
      end
    end else if (flush_i) begin
      valid_reg <= '0;
    end else if (advance) begin
      valid_reg   <= {valid_reg[STAGES-2:0], accept};
      prod_reg[0] <= {b_mag, a_mag};
      ctl_reg[0]  <= ctl_in;
      for (int i = 1; i < STAGES-1; i++) begin
        prod_reg[i] <= (i == 1) ? mag_prod : prod_reg[i-1];
        ctl_reg[i]  <= ctl_reg[i-1];
      end
    end
  end

  // Output register: captures the finished result whenever the pipe moves.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      rd_reg   <= '0;
      full_reg <= '0;
      tag_reg  <= '0;
    end else if (advance && !flush_i) begin
      rd_reg   <= rd_next;
      full_reg <= full_next;
      tag_reg  <= last_ctl.tag;
    end
  end

  assign valid_o       = valid_reg[STAGES-1];
  assign rd_o          = valid_o ? rd_reg   : '0;
  assign rd_complete_o = valid_o ? full_reg : '0;
  assign tag_o         = valid_o ? tag_reg  : '0;
  assign busy_o        = |valid_reg;

endmodule

// File: tb/tb_scalar_pipelined_multiplication_unit.sv
// Directed bench for scalar_pipelined_multiplication_unit: one 64-bit/3-stage
// instance plus 32-bit instances at 2 and 4 stages sharing the data inputs.
module tb_scalar_pipelined_multiplication_unit;

  typedef struct {
    logic [2:0]   f3;
    logic         word;
    logic [63:0]  rs1;
    logic [63:0]  rs2;
    logic [63:0]  rd;
    logic [127:0] full;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, flush, req, rdy, word;
  logic [2:0]  f3;
  logic [63:0] rs1, rs2;
  logic [4:0]  tag;
  int          sel;
  int          errors = 0;
  int          checks = 0;

  vec_t v64 [12];
  vec_t v32 [4];

  logic req_m, req_a, req_b, rdy_m, rdy_a, rdy_b;
  assign req_m = req && (sel == 0);
  assign req_a = req && (sel == 1);
  assign req_b = req && (sel == 2);
  assign rdy_m = (sel == 0) ? rdy : 1'b1;
  assign rdy_a = (sel == 1) ? rdy : 1'b1;
  assign rdy_b = (sel == 2) ? rdy : 1'b1;

  logic         m_ready, m_valid, m_busy;
  logic [63:0]  m_rd;
  logic [127:0] m_full;
  logic [4:0]   m_tag;
  logic         a_ready, a_valid, a_busy;
  logic [31:0]  a_rd;
  logic [63:0]  a_full;
  logic [4:0]   a_tag;
  logic         b_ready, b_valid, b_busy;
  logic [31:0]  b_rd;
  logic [63:0]  b_full;
  logic [4:0]   b_tag;

  scalar_pipelined_multiplication_unit #(.XLEN(64), .STAGES(3), .TAG_W(5)) dut_m (
    .clock_i(clk), .reset_ni(rst_n), .flush_i(flush), .request_i(req_m),
    .ready_o(m_ready), .funct3_i(f3), .word_i(word), .rs1_i(rs1), .rs2_i(rs2),
    .tag_i(tag), .valid_o(m_valid), .ready_i(rdy_m), .rd_o(m_rd),
    .rd_complete_o(m_full), .tag_o(m_tag), .busy_o(m_busy));

  scalar_pipelined_multiplication_unit #(.XLEN(32), .STAGES(2), .TAG_W(5)) dut_a (
    .clock_i(clk), .reset_ni(rst_n), .flush_i(flush), .request_i(req_a),
    .ready_o(a_ready), .funct3_i(f3), .word_i(1'b0), .rs1_i(rs1[31:0]),
    .rs2_i(rs2[31:0]), .tag_i(tag), .valid_o(a_valid), .ready_i(rdy_a),
    .rd_o(a_rd), .rd_complete_o(a_full), .tag_o(a_tag), .busy_o(a_busy));

  scalar_pipelined_multiplication_unit #(.XLEN(32), .STAGES(4), .TAG_W(5)) dut_b (
    .clock_i(clk), .reset_ni(rst_n), .flush_i(flush), .request_i(req_b),
    .ready_o(b_ready), .funct3_i(f3), .word_i(1'b0), .rs1_i(rs1[31:0]),
    .rs2_i(rs2[31:0]), .tag_i(tag), .valid_o(b_valid), .ready_i(rdy_b),
    .rd_o(b_rd), .rd_complete_o(b_full), .tag_o(b_tag), .busy_o(b_busy));

  logic         cur_ready, cur_valid, cur_busy;
  logic [63:0]  cur_rd;
  logic [127:0] cur_full;
  logic [4:0]   cur_tag;
  int           cur_stages;

  always_comb begin
    cur_ready = m_ready; cur_valid = m_valid; cur_busy = m_busy;
    cur_rd = m_rd; cur_full = m_full; cur_tag = m_tag; cur_stages = 3;
    if (sel == 1) begin
      cur_ready = a_ready; cur_valid = a_valid; cur_busy = a_busy;
      cur_rd = {32'd0, a_rd}; cur_full = {64'd0, a_full}; cur_tag = a_tag; cur_stages = 2;
    end else if (sel == 2) begin
      cur_ready = b_ready; cur_valid = b_valid; cur_busy = b_busy;
      cur_rd = {32'd0, b_rd}; cur_full = {64'd0, b_full}; cur_tag = b_tag; cur_stages = 4;
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v, input logic [4:0] t);
    f3 = v.f3; word = v.word; rs1 = v.rs1; rs2 = v.rs2; tag = t;
  endtask

  // Single isolated request: latency, result, tag, and no duplicate afterwards.
  task automatic run_single(input vec_t v, input logic [4:0] t, input string nm);
    int cnt = 0;
    @(negedge clk);
    apply(v, t); req = 1'b1; rdy = 1'b1;
    #1 check({nm, " ready"}, 128'(cur_ready), 128'(1));
    @(negedge clk);
    req = 1'b0;
    while (!cur_valid && cnt < 12) begin
      @(negedge clk);
      cnt++;
    end
    check({nm, " latency"}, 128'(cnt), 128'(cur_stages - 1));
    check({nm, " rd"}, 128'(cur_rd), 128'(v.rd));
    check({nm, " full"}, cur_full, v.full);
    check({nm, " tag"}, 128'(cur_tag), 128'(t));
    $display("txn %s sel=%0d tag=%0d lat=%0d rd=%h", nm, sel, t, cnt, cur_rd);
    @(negedge clk);
    check({nm, " drained"}, 128'(cur_valid), 128'(0));
  endtask

  // Four back-to-back requests, output stalled 3 cycles when tag 0 appears.
  task automatic run_bp(input bit use32, input string nm);
    int issued = 0, got = 0, cyc = 0, stall_left = 0, extra = 0;
    bit seen0 = 0, held_ok = 0, stalled_seen = 0;
    logic [63:0]  held_rd;
    logic [127:0] held_full;
    logic [4:0]   held_tag;
    vec_t bv;
    rdy = 1'b1; req = 1'b0;
    while (got < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (issued < 4) begin
        bv = use32 ? v32[issued] : v64[issued];
        apply(bv, 5'(issued));
        req = 1'b1;
      end else begin
        req = 1'b0;
      end
      if (cur_valid && cur_tag == 5'd0 && !seen0) begin
        seen0 = 1; stall_left = 3;
      end
      rdy = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      #1;
      check({nm, " ready"}, 128'(cur_ready), 128'(!(cur_valid && !rdy)));
      if (held_ok) begin
        check({nm, " hold rd"}, 128'(cur_rd), 128'(held_rd));
        check({nm, " hold full"}, cur_full, held_full);
        check({nm, " hold tag"}, 128'(cur_tag), 128'(held_tag));
      end
      held_ok = 0;
      if (cur_valid && !rdy) begin
        held_rd = cur_rd; held_full = cur_full; held_tag = cur_tag;
        held_ok = 1; stalled_seen = 1;
      end else if (cur_valid) begin
        bv = use32 ? v32[got] : v64[got];
        check({nm, " order tag"}, 128'(cur_tag), 128'(got));
        check({nm, " rd"}, 128'(cur_rd), 128'(bv.rd));
        $display("txn %s sel=%0d tag=%0d rd=%h cycle=%0d", nm, sel, cur_tag, cur_rd, cyc);
        got++;
      end
      if (req && !(cur_valid && !rdy)) issued++;
    end
    req = 1'b0; rdy = 1'b1;
    check({nm, " delivered"}, 128'(got), 128'(4));
    check({nm, " stall seen"}, 128'(stalled_seen), 128'(1));
    repeat (4) begin
      @(negedge clk);
      if (cur_valid) extra++;
    end
    check({nm, " no extra"}, 128'(extra), 128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int extra;
    int cnt;
    v64[0]  = '{3'b000, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB,
                {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFEB}};
    v64[1]  = '{3'b001, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 128'd1};
    v64[2]  = '{3'b011, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFE, {64'hFFFF_FFFF_FFFF_FFFE, 64'd1}};
    v64[3]  = '{3'b010, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                64'hFFFF_FFFF_FFFF_FFFF, {64'hFFFF_FFFF_FFFF_FFFF, 64'd1}};
    v64[4]  = '{3'b100, 1'b0, 64'd5, 64'd6, 64'd0, 128'd0};
    v64[5]  = '{3'b000, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE,
                {64'd0, 64'h0000_0000_FFFF_FFFE}};
    v64[6]  = '{3'b000, 1'b1, 64'hDEAD_BEEF_0000_0003, 64'd5, 64'd15, 128'd15};
    v64[7]  = '{3'b000, 1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, {64'd1, 64'd0}};
    v64[8]  = '{3'b001, 1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 64'd1, {64'd1, 64'd0}};
    v64[9]  = '{3'b010, 1'b0, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1,
                {64'd1, 64'hFFFF_FFFF_FFFF_FFFE}};
    v64[10] = '{3'b001, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
                64'h4000_0000_0000_0000, {64'h4000_0000_0000_0000, 64'd0}};
    v64[11] = '{3'b011, 1'b1, 64'h1234_5678_FFFF_FFFF, 64'hABCD_0000_FFFF_FFFF, 64'd1, 128'd1};

    v32[0] = '{3'b000, 1'b0, 64'd7, 64'hFFFF_FFFD, 64'hFFFF_FFEB, 128'hFFFF_FFFF_FFFF_FFEB};
    v32[1] = '{3'b001, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'd0, 128'd1};
    v32[2] = '{3'b011, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE, 128'hFFFF_FFFE_0000_0001};
    v32[3] = '{3'b010, 1'b0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 128'hFFFF_FFFF_0000_0001};

    rst_n = 1'b0; flush = 1'b0; req = 1'b0; rdy = 1'b1; sel = 0;
    f3 = 3'b000; word = 1'b0; rs1 = '0; rs2 = '0; tag = '0;
    #1;
    check("reset valid", 128'(m_valid), 128'(0));
    check("reset busy", 128'(m_busy), 128'(0));
    check("reset rd", 128'(m_rd), 128'(0));
    check("reset full", m_full, 128'(0));
    check("reset tag", 128'(m_tag), 128'(0));
    check("reset ready", 128'(m_ready), 128'(1));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_single(v64[i], 5'(i), "v64");
    run_bp(1'b0, "bp64");

    // Flush with two operations in flight and a concurrent request.
    @(negedge clk); apply(v64[0], 5'd20); req = 1'b1;
    @(negedge clk); apply(v64[1], 5'd21);
    @(negedge clk); apply(v64[2], 5'd22); flush = 1'b1;
    #1 check("flush busy before", 128'(m_busy), 128'(1));
    @(negedge clk); flush = 1'b0; req = 1'b0;
    check("flush busy after", 128'(m_busy), 128'(0));
    check("flush valid after", 128'(m_valid), 128'(0));
    extra = 0;
    repeat (6) begin @(negedge clk); if (m_valid) extra++; end
    check("flush none presented", 128'(extra), 128'(0));
    run_single(v64[3], 5'd23, "post flush");

    // Flush while a result is held by stall.
    @(negedge clk); apply(v64[5], 5'd24); req = 1'b1; rdy = 1'b0;
    @(negedge clk); req = 1'b0;
    cnt = 0;
    while (!m_valid && cnt < 12) begin @(negedge clk); cnt++; end
    check("stall flush latency", 128'(cnt), 128'(2));
    @(negedge clk);
    check("stall flush held tag", 128'(m_tag), 128'(24));
    flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    check("stall flush valid", 128'(m_valid), 128'(0));
    check("stall flush busy", 128'(m_busy), 128'(0));
    rdy = 1'b1;
    extra = 0;
    repeat (3) begin @(negedge clk); if (m_valid) extra++; end
    check("stall flush discarded", 128'(extra), 128'(0));

    // Asynchronous reset with three operations in flight.
    @(negedge clk); apply(v64[0], 5'd10); req = 1'b1;
    @(negedge clk); apply(v64[1], 5'd11);
    @(negedge clk); apply(v64[2], 5'd12);
    @(posedge clk); #1;
    check("rst pre valid", 128'(m_valid), 128'(1));
    req = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst valid", 128'(m_valid), 128'(0));
    check("rst busy", 128'(m_busy), 128'(0));
    check("rst rd", 128'(m_rd), 128'(0));
    check("rst ready", 128'(m_ready), 128'(1));
    @(negedge clk); rst_n = 1'b1;
    extra = 0;
    repeat (6) begin @(negedge clk); if (m_valid) extra++; end
    check("rst no stale", 128'(extra), 128'(0));
    run_single(v64[4], 5'd13, "post reset");

    for (int s = 1; s <= 2; s++) begin
      sel = s;
      for (int i = 0; i < 4; i++) run_single(v32[i], 5'(i), "v32");
      run_bp(1'b1, "bp32");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
